usb_rx_packet_ctrl: RTL and testbench

- Sequences the USB receiver datapath (receiver FIFO, PID detector, error flag) into whole-packet transactions for the endpoint buffer and AHB-side status logic.
- Pops bytes from the receiver FIFO and writes them into the data buffer; counts them and strips the trailing CRC bytes from the count.
- Classifies the packet from the PID and holds a status/handshake record until the host side acknowledges it.

---
 rtl/usb_rx_pkg.sv | 45 ++++
 rtl/usb_crc16_rx.sv | 29 ++
 rtl/usb_rx_packet_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_usb_rx_packet_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet controller.
// CRC16 helpers are only referenced when RX_CRC16_EN is defined.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_IN    = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_DATA0 = 3'd5,
        PKT_DATA1 = 3'd6,
        PKT_ERROR = 3'd7
    } rx_packet_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    // Reflected CRC16 over one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16_rx.sv
// Byte-wide USB CRC16 accumulator with synchronous clear and update enable.
// Instantiated by usb_rx_packet_ctrl only when RX_CRC16_EN is defined.
module usb_crc16_rx
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    // Accumulate each written byte; restart from the seed between packets.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else if (clr_i) begin
            crc_q <= CRC16_INIT;
        end else if (en_i) begin
            crc_q <= crc16_byte(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet controller: pops the receiver FIFO into the endpoint
// data buffer, drops the PID byte, counts payload and classifies the packet.
// Optional build macro RX_CRC16_EN adds a CRC16 residual check on data packets.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_DATA = 64,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rcving,
    input  logic             r_error,
    input  logic [3:0]       pid,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_rdata,
    output logic             fifo_ren,
    input  logic             buf_ready,
    output logic             buf_wen,
    output logic [7:0]       buf_wdata,
    output logic             rx_active,
    output logic [2:0]       rx_packet,
    output logic             rx_valid,
    output logic [CNT_W-1:0] rx_bytes,
    input  logic             rx_ack
);

    // Written-byte count at which one more byte means payload overflow.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DATA + 2);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q;
    rx_packet_t       rx_packet_q;
    logic [CNT_W-1:0] rx_bytes_q;
    logic             rx_valid_q;

    logic             pop_c, wen_c, ovf_c;
    rx_packet_t       cls_code;
    logic [CNT_W-1:0] cls_bytes;
    logic             crc_ok;

`ifdef RX_CRC16_EN
    logic [15:0] crc_val;

    usb_crc16_rx u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr_i  ((state_q == IDLE) || (state_q == DONE)),
        .en_i   (wen_c),
        .data_i (fifo_rdata),
        .crc_o  (crc_val)
    );

    assign crc_ok = (crc_val == CRC16_RESIDUAL);
`else
    assign crc_ok = 1'b1;
`endif

    // FIFO-to-buffer transfer strobes; the first pop of a packet is the PID.
    always_comb begin
        pop_c = 1'b0;
        wen_c = 1'b0;
        ovf_c = 1'b0;
        case (state_q)
            RECV, DRAIN: begin
                ovf_c = first_q && !fifo_empty && (cnt_q >= CNT_LIMIT);
                if (!r_error && !ovf_c && !fifo_empty && buf_ready) begin
                    pop_c = 1'b1;
                    wen_c = first_q;
                end
            end
            FLUSH: pop_c = !fifo_empty;
            default: ;
        endcase
    end

    // Saturating count of bytes written to the buffer.
    always_comb begin
        cnt_d = cnt_q;
        if (wen_c && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Packet classification from the PID and the written-byte count.
    always_comb begin
        cls_code  = PKT_ERROR;
        cls_bytes = '0;
        case (pid)
            PID_OUT:   cls_code = PKT_OUT;
            PID_IN:    cls_code = PKT_IN;
            PID_ACK:   cls_code = PKT_ACK;
            PID_NAK:   cls_code = PKT_NAK;
            PID_DATA0: cls_code = PKT_DATA0;
            PID_DATA1: cls_code = PKT_DATA1;
            default:   cls_code = PKT_ERROR;
        endcase
        if ((pid == PID_DATA0) || (pid == PID_DATA1)) begin
            if ((cnt_q < CNT_W'(2)) || !crc_ok) begin
                cls_code = PKT_ERROR;
            end else begin
                cls_bytes = cnt_q - CNT_W'(2);
            end
        end else if (cnt_q != '0) begin
            cls_code = PKT_ERROR;
        end
    end

    // Packet sequencing FSM with registered status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            rx_packet_q <= PKT_NONE;
            rx_bytes_q  <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_q | pop_c;
            case (state_q)
                IDLE: begin
                    if (rcving) begin
                        state_q <= RECV;
                        cnt_q   <= '0;
                        first_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (r_error || ovf_c) begin
                        state_q <= FLUSH;
                    end else if (!rcving) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_error || ovf_c) begin
                        state_q <= FLUSH;
                    end else if (fifo_empty) begin
                        state_q     <= DONE;
                        rx_packet_q <= cls_code;
                        rx_bytes_q  <= cls_bytes;
                        rx_valid_q  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fifo_empty && !rcving) begin
                        state_q     <= DONE;
                        rx_packet_q <= PKT_ERROR;
                        rx_bytes_q  <= '0;
                        rx_valid_q  <= 1'b1;
                    end
                end
                DONE: begin
                    // A following packet waits in the FIFO until the host acknowledges.
                    if (rx_ack) begin
                        rx_packet_q <= PKT_NONE;
                        rx_bytes_q  <= '0;
                        rx_valid_q  <= 1'b0;
                        cnt_q       <= '0;
                        first_q     <= 1'b0;
                        state_q     <= rcving ? RECV : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_ren  = pop_c;
    assign buf_wen   = wen_c;
    assign buf_wdata = wen_c ? fifo_rdata : 8'h00;
    assign rx_active = (state_q == RECV) || (state_q == DRAIN) || (state_q == FLUSH);
    assign rx_packet = rx_packet_q;
    assign rx_bytes  = rx_bytes_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl with a behavioural receiver FIFO and
// a capture memory for bytes written to the data buffer.
module tb_usb_rx_packet_ctrl;

    localparam int MAX_DATA = 64;
    localparam int CNT_W    = 7;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             rcving = 1'b0;
    logic             r_error = 1'b0;
    logic [3:0]       pid = 4'h0;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             fifo_ren;
    logic             buf_ready = 1'b1;
    logic             buf_wen;
    logic [7:0]       buf_wdata;
    logic             rx_active;
    logic [2:0]       rx_packet;
    logic             rx_valid;
    logic [CNT_W-1:0] rx_bytes;
    logic             rx_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:511];
    logic [7:0] cap [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    int wens = 0;
    int nr_pops = 0;

    logic [7:0] exp_b [0:15];
    int         exp_n;

    usb_rx_packet_ctrl #(.MAX_DATA(MAX_DATA), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rcving     (rcving),
        .r_error    (r_error),
        .pid        (pid),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .buf_ready  (buf_ready),
        .buf_wen    (buf_wen),
        .buf_wdata  (buf_wdata),
        .rx_active  (rx_active),
        .rx_packet  (rx_packet),
        .rx_valid   (rx_valid),
        .rx_bytes   (rx_bytes),
        .rx_ack     (rx_ack)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr[8:0]];

    always @(posedge clk) begin
        if (fifo_ren) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
            if (!buf_ready) nr_pops <= nr_pops + 1;
        end
        if (buf_wen) begin
            cap[wens[8:0]] <= buf_wdata;
            wens <= wens + 1;
        end
    end

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // PID, n payload bytes base+i, then the transmitted CRC16 (optionally corrupted).
    task automatic push_data_pkt(input logic [7:0] pidb, input int n, input logic [7:0] base,
                                 input logic flip);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        push(pidb);
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            exp_b[i] = b;
            c = crc_upd(c, b);
            push(b);
        end
        c = ~c;
        exp_b[n]     = c[7:0] ^ {7'd0, flip};
        exp_b[n + 1] = c[15:8];
        exp_n = n + 2;
        push(exp_b[n]);
        push(exp_b[n + 1]);
    endtask

    task automatic pulse_rcving(input int cycles);
        @(posedge clk); #1 rcving = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rcving = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!rx_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_active, rx_valid, fifo_ren, buf_wen, rx_packet, rx_bytes, buf_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {rx_active, rx_valid, fifo_ren, buf_wen, rx_packet, rx_bytes, buf_wdata});
        end
        @(posedge clk); #1 n_rst = 1'b1;
    endtask

    task automatic test_ack();
        int p0, w0;
        p0 = pops; w0 = wens;
        pid = 4'b0010;
        push(8'hD2);
        @(posedge clk); #1 rcving = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rx_active !== 1'b1) begin errors++; $display("FAIL ack_active: got %b required 1", rx_active); end
        repeat (2) @(posedge clk);
        #1 rcving = 1'b0;
        wait_valid(20);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL ack_valid: got %b required 1", rx_valid); end
        checks++;
        if (rx_packet !== 3'd3) begin errors++; $display("FAIL ack_code: got %0d required 3", rx_packet); end
        checks++;
        if (rx_bytes !== 7'd0) begin errors++; $display("FAIL ack_bytes: got %0d required 0", rx_bytes); end
        checks++;
        if (pops - p0 !== 1) begin errors++; $display("FAIL ack_pops: got %0d required 1", pops - p0); end
        checks++;
        if (wens - w0 !== 0) begin errors++; $display("FAIL ack_wen: got %0d required 0", wens - w0); end
        repeat (4) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL ack_hold: got %b required 1", rx_valid); end
        ack_pulse();
        @(negedge clk);
        checks++;
        if ({rx_valid, rx_packet} !== 4'd0) begin
            errors++; $display("FAIL ack_clear: got valid=%b code=%0d required 0/0", rx_valid, rx_packet);
        end
    endtask

    task automatic run_data(input logic [7:0] pidb, input logic [3:0] pidv, input int n,
                            input logic [7:0] base, input logic flip,
                            input logic [2:0] code, input logic [6:0] nbytes);
        int p0, w0;
        p0 = pops; w0 = wens;
        pid = pidv;
        push_data_pkt(pidb, n, base, flip);
        pulse_rcving(n + 5);
        wait_valid(30);
        checks++;
        if (rx_packet !== code) begin errors++; $display("FAIL data_code: got %0d required %0d", rx_packet, code); end
        checks++;
        if (rx_bytes !== nbytes) begin errors++; $display("FAIL data_bytes: got %0d required %0d", rx_bytes, nbytes); end
        checks++;
        if (wens - w0 !== n + 2) begin errors++; $display("FAIL data_wen: got %0d required %0d", wens - w0, n + 2); end
        checks++;
        if (pops - p0 !== n + 3) begin errors++; $display("FAIL data_pops: got %0d required %0d", pops - p0, n + 3); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (cap[w0 + i] !== exp_b[i]) begin
                errors++; $display("FAIL data_byte%0d: got %h required %h", i, cap[w0 + i], exp_b[i]);
            end
        end
        ack_pulse();
    endtask

    task automatic test_data0();
        run_data(8'hC3, 4'b0011, 3, 8'h01, 1'b0, 3'd5, 7'd3);
`ifdef RX_CRC16_EN
        run_data(8'hC3, 4'b0011, 3, 8'h01, 1'b1, 3'd7, 7'd0);
`endif
    endtask

    task automatic test_buf_ready_toggle();
        int p0, w0, nr0;
        p0 = pops; w0 = wens; nr0 = nr_pops;
        pid = 4'b1011;
        push_data_pkt(8'h4B, 4, 8'hA1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 buf_ready = i[0];
            rcving = (i < 14);
        end
        #1 buf_ready = 1'b1;
        wait_valid(20);
        checks++;
        if (nr_pops - nr0 !== 0) begin errors++; $display("FAIL rdy_pop_low: got %0d required 0", nr_pops - nr0); end
        checks++;
        if (rx_packet !== 3'd6) begin errors++; $display("FAIL rdy_code: got %0d required 6", rx_packet); end
        checks++;
        if (rx_bytes !== 7'd4) begin errors++; $display("FAIL rdy_bytes: got %0d required 4", rx_bytes); end
        checks++;
        if (pops - p0 !== 7) begin errors++; $display("FAIL rdy_pops: got %0d required 7", pops - p0); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (cap[w0 + i] !== exp_b[i]) begin
                errors++; $display("FAIL rdy_byte%0d: got %h required %h", i, cap[w0 + i], exp_b[i]);
            end
        end
        ack_pulse();
    endtask

    task automatic test_r_error();
        int p0, w0;
        p0 = pops; w0 = wens;
        pid = 4'b0011;
        buf_ready = 1'b0;
        push(8'hC3); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        @(posedge clk); #1 rcving = 1'b1;
        @(posedge clk); #1 r_error = 1'b1;
        @(posedge clk); #1 r_error = 1'b0; rcving = 1'b0; buf_ready = 1'b1;
        wait_valid(20);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL err_valid: got %b required 1", rx_valid); end
        checks++;
        if (rx_packet !== 3'd7) begin errors++; $display("FAIL err_code: got %0d required 7", rx_packet); end
        checks++;
        if (wens - w0 !== 0) begin errors++; $display("FAIL err_wen: got %0d required 0", wens - w0); end
        checks++;
        if (pops - p0 !== 5) begin errors++; $display("FAIL err_pops: got %0d required 5", pops - p0); end
        ack_pulse();
    endtask

    task automatic test_overflow();
        int p0, w0;
        p0 = pops; w0 = wens;
        pid = 4'b0011;
        push(8'hC3);
        for (int i = 0; i < MAX_DATA + 3; i++) push(8'(i));
        pulse_rcving(75);
        wait_valid(40);
        checks++;
        if (rx_packet !== 3'd7) begin errors++; $display("FAIL ovf_code: got %0d required 7", rx_packet); end
        checks++;
        if (rx_bytes !== 7'd0) begin errors++; $display("FAIL ovf_bytes: got %0d required 0", rx_bytes); end
        checks++;
        if (wens - w0 !== MAX_DATA + 2) begin errors++; $display("FAIL ovf_wen: got %0d required %0d", wens - w0, MAX_DATA + 2); end
        checks++;
        if (pops - p0 !== MAX_DATA + 4) begin errors++; $display("FAIL ovf_pops: got %0d required %0d", pops - p0, MAX_DATA + 4); end
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        int p0;
        pid = 4'b0010;
        push(8'hD2);
        pulse_rcving(3);
        wait_valid(20);
        p0 = pops;
        pid = 4'b1010;
        push(8'h5A);
        @(posedge clk); #1 rcving = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_ren !== 1'b0) begin errors++; $display("FAIL b2b_hold_ren%0d: got %b required 0", i, fifo_ren); end
        end
        ack_pulse();
        @(negedge clk);
        checks++;
        if ({rx_active, rx_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_restart: got active=%b valid=%b required 1/0", rx_active, rx_valid);
        end
        @(posedge clk); #1 rcving = 1'b0;
        wait_valid(20);
        checks++;
        if (rx_packet !== 3'd4) begin errors++; $display("FAIL b2b_code: got %0d required 4", rx_packet); end
        checks++;
        if (pops - p0 !== 1) begin errors++; $display("FAIL b2b_pops: got %0d required 1", pops - p0); end
        ack_pulse();
    endtask

    task automatic test_reset_midpacket();
        pid = 4'b0011;
        push(8'hC3); push(8'h01); push(8'h02);
        @(posedge clk); #1 rcving = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        checks++;
        if ({rx_active, rx_valid, fifo_ren, buf_wen, rx_packet, rx_bytes, buf_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_async: got %b required all zero",
                     {rx_active, rx_valid, fifo_ren, buf_wen, rx_packet, rx_bytes, buf_wdata});
        end
        rcving = 1'b0;
        wr_ptr = rd_ptr;
        @(posedge clk); #1 n_rst = 1'b1;
        pid = 4'b0001;
        push(8'hE1);
        @(negedge clk);
        checks++;
        if ({rx_active, fifo_ren} !== 2'b00) begin
            errors++; $display("FAIL rst_idle: got active=%b ren=%b required 0/0", rx_active, fifo_ren);
        end
        pulse_rcving(3);
        wait_valid(20);
        checks++;
        if (rx_packet !== 3'd1) begin errors++; $display("FAIL out_code: got %0d required 1", rx_packet); end
        checks++;
        if (rx_bytes !== 7'd0) begin errors++; $display("FAIL out_bytes: got %0d required 0", rx_bytes); end
        ack_pulse();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        test_reset();
        test_ack();
        test_data0();
        test_buf_ready_toggle();
        test_r_error();
        test_overflow();
        test_back_to_back();
        test_reset_midpacket();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
